store_buffer: RTL



---
 rtl/store_buffer_pkg.sv | 21 ++
 rtl/sb_bytemask_gen.sv | 25 ++
 rtl/store_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared LSU store-buffer definitions: entry layout and store size decode.
package store_buffer_pkg;

  localparam int SB_LLEN    = 64;
  localparam int SB_PA_BITS = 56;
  localparam int SB_MW      = SB_LLEN / 8;
  localparam int SB_OB      = $clog2(SB_MW);

  typedef struct packed {
    logic                        valid;
    logic [SB_PA_BITS-SB_OB-1:0] wadr;
    logic [SB_LLEN-1:0]          data;
    logic [SB_MW-1:0]            mask;
  } sb_entry_t;

  // funct3[2] selects a 16-byte access; otherwise 1 << funct3[1:0] bytes.
  function automatic logic [4:0] sb_size_bytes(input logic [2:0] funct3);
    sb_size_bytes = funct3[2] ? 5'd16 : (5'd1 << funct3[1:0]);
  endfunction

endpackage

// File: rtl/sb_bytemask_gen.sv
// Per-byte enable generator: size from funct3, shifted by the byte offset in the word.
module sb_bytemask_gen
  import store_buffer_pkg::*;
#(
  parameter int LLEN       = SB_LLEN,
  parameter bit HONOR_QUAD = 1'b1,
  localparam int MW        = LLEN / 8,
  localparam int OB        = $clog2(MW)
) (
  input  logic [2:0]    funct3,
  input  logic [OB-1:0] offset,
  output logic [MW-1:0] mask
);

  logic [16:0] ones;
  logic [47:0] shifted;

  // Bits shifted past MW belong to the split-off half of a misaligned access.
  always_comb begin
    ones    = (17'd1 << sb_size_bytes({funct3[2] & HONOR_QUAD, funct3[1:0]})) - 17'd1;
    shifted = {31'b0, ones} << offset;
    mask    = shifted[MW-1:0];
  end

endmodule

// File: rtl/store_buffer.sv
// LSU store queue: masks, coalesces and drains stores; flags loads hitting pending stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int LLEN    = SB_LLEN,
  parameter int PA_BITS = SB_PA_BITS,
  parameter int DEPTH   = 4,
  localparam int MW     = LLEN / 8,
  localparam int OB     = $clog2(MW),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StoreValidM,
  input  logic [2:0]         LSUFunct3M,
  input  logic [PA_BITS-1:0] PAdrM,
  input  logic [LLEN-1:0]    LittleEndianWriteDataM,
  output logic               StoreReadyM,
  input  logic               LoadValidM,
  input  logic [PA_BITS-1:0] LoadAdrM,
  input  logic [2:0]         LoadFunct3M,
  output logic               LoadHitSB,
  output logic               DrainValid,
  output logic [PA_BITS-1:0] DrainAdr,
  output logic [LLEN-1:0]    DrainData,
  output logic [MW-1:0]      DrainByteMask,
  input  logic               DrainReady,
  output logic               SBEmpty,
  output logic               SBFull
);

  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   ONE_CNT  = (PW+1)'(1);
  localparam logic [PW:0]   TWO_CNT  = (PW+1)'(2);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  sb_entry_t entries [DEPTH];
  logic [PW-1:0] head, tail, youngest;
  logic [PW:0]   count;

  logic [MW-1:0]         store_mask, load_mask;
  logic [PA_BITS-OB-1:0] store_wadr, load_wadr;
  logic                  enq, deq, merge;

  sb_bytemask_gen #(.LLEN(LLEN), .HONOR_QUAD(1'b1)) u_store_mask (
    .funct3 (LSUFunct3M),
    .offset (PAdrM[OB-1:0]),
    .mask   (store_mask)
  );

  sb_bytemask_gen #(.LLEN(LLEN), .HONOR_QUAD(1'b0)) u_load_mask (
    .funct3 (LoadFunct3M),
    .offset (LoadAdrM[OB-1:0]),
    .mask   (load_mask)
  );

  assign store_wadr  = PAdrM[PA_BITS-1:OB];
  assign load_wadr   = LoadAdrM[PA_BITS-1:OB];
  assign youngest    = tail - ONE_PTR;

  assign SBFull      = (count == FULL_CNT);
  assign SBEmpty     = (count == '0);
  assign StoreReadyM = !SBFull;
  assign DrainValid  = !SBEmpty;

  assign enq   = StoreValidM && !SBFull;
  assign deq   = DrainValid && DrainReady;
  // The head may be mid-handshake, so only a non-head youngest entry absorbs a store.
  assign merge = enq && (count >= TWO_CNT) && entries[youngest].valid &&
                 (entries[youngest].wadr == store_wadr) && (youngest != head);

  always_comb begin
    DrainAdr      = '0;
    DrainData     = '0;
    DrainByteMask = '0;
    if (DrainValid) begin
      DrainAdr      = {entries[head].wadr, {OB{1'b0}}};
      DrainData     = entries[head].data;
      DrainByteMask = entries[head].mask;
    end
  end

  always_comb begin
    LoadHitSB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LoadValidM && entries[i].valid && (entries[i].wadr == load_wadr) &&
          |(entries[i].mask & load_mask))
        LoadHitSB = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (deq) begin
        entries[head].valid <= 1'b0;
        head                <= head + ONE_PTR;
      end
      if (merge) begin
        for (int b = 0; b < MW; b++) begin
          if (store_mask[b])
            entries[youngest].data[b*8 +: 8] <= LittleEndianWriteDataM[b*8 +: 8];
        end
        entries[youngest].mask <= entries[youngest].mask | store_mask;
      end else if (enq) begin
        entries[tail] <= '{valid: 1'b1, wadr: store_wadr,
                           data: LittleEndianWriteDataM, mask: store_mask};
        tail          <= tail + ONE_PTR;
      end
      case ({enq && !merge, deq})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

endmodule
